pic_ctrl_seq: RTL and testbench

- Parametrised successor to the 8259-style control logic: NUM_IRQ request channels, an IRR/ISR/IMR datapath, a priority resolver and a two-pulse INTA sequencer.
- Adds fully-nested masking against ISR, rotating priority, automatic EOI (AEOI) and specific EOI.
- Sits between the raw IR pins and the CPU-side interface.
- Command/ICW decode is upstream. This block receives decoded mode bits and EOI strobes.

---
 rtl/pic_pkg.sv | 24 ++
 rtl/pic_prio_resolver.sv | 48 ++++
 rtl/pic_ctrl_seq.sv | 160 ++++++++++++++++
 tb/tb_pic_ctrl_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the pic_ctrl_seq interrupt controller.
// Holds the acknowledge FSM encoding and the priority-rotation index helper.
package pic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    // (base + off) mod n without a divider; needs base < n and off <= n
    function automatic int unsigned rot_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        int unsigned s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority resolver: scans requests and in-service bits starting
// just after the lowest-priority pointer and applies full nesting.
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic [ID_W-1:0]    lp,
    output logic               cand_valid,
    output logic [ID_W-1:0]    cand_id,
    output logic               isr_any,
    output logic [ID_W-1:0]    isr_top_id
);

    logic            req_any;
    logic [ID_W-1:0] req_rank;
    logic [ID_W-1:0] isr_rank;
    logic [ID_W-1:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        req_any    = 1'b0;
        req_rank   = '0;
        cand_id    = '0;
        isr_any    = 1'b0;
        isr_rank   = '0;
        isr_top_id = '0;
        idx        = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = ID_W'(rot_idx(32'(lp), 32'(i + 1), 32'(NUM_IRQ)));
            if (req[idx]) begin
                req_any  = 1'b1;
                req_rank = ID_W'(i);
                cand_id  = idx;
            end
            if (isr[idx]) begin
                isr_any    = 1'b1;
                isr_rank   = ID_W'(i);
                isr_top_id = idx;
            end
        end
        cand_valid = req_any && (!isr_any || (req_rank < isr_rank));
    end

endmodule

// File: rtl/pic_ctrl_seq.sv
// 8259-style interrupt control: IRR/ISR datapath, rotating nested priority,
// AEOI/specific EOI and a two-pulse INTA acknowledge sequencer.
module pic_ctrl_seq
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IRQ-1:0]    ir,
    input  logic [NUM_IRQ-1:0]    imr,
    input  logic                  ltim,
    input  logic                  aeoi,
    input  logic                  rotate,
    input  logic [VEC_W-ID_W-1:0] vec_base,
    input  logic                  inta,
    input  logic                  eoi,
    input  logic                  seoi,
    input  logic [ID_W-1:0]       seoi_id,
    output logic                  intr,
    output logic [VEC_W-1:0]      vec,
    output logic                  vec_valid,
    output logic [NUM_IRQ-1:0]    irr,
    output logic [NUM_IRQ-1:0]    isr
);

    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_IRQ - 1);

    state_t state;
    state_t state_n;

    logic [NUM_IRQ-1:0] ir_q;
    logic [NUM_IRQ-1:0] irr_n;
    logic [NUM_IRQ-1:0] isr_n;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] set_mask;
    logic [ID_W-1:0]    lp;
    logic [ID_W-1:0]    lp_eff;
    logic [ID_W-1:0]    lp_n;
    logic [ID_W-1:0]    id;
    logic [ID_W-1:0]    cand_id;
    logic [ID_W-1:0]    isr_top_id;
    logic               cand_valid;
    logic               isr_any;
    logic               spur;
    logic               ack;
    logic               fin;
    logic               seoi_hit;
    logic               eoi_hit;
    logic               aeoi_hit;

    // Fixed priority pins the pointer so channel 0 is always highest
    assign lp_eff = rotate ? lp : LAST;

    pic_prio_resolver #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .req        (irr & ~imr),
        .isr        (isr),
        .lp         (lp_eff),
        .cand_valid (cand_valid),
        .cand_id    (cand_id),
        .isr_any    (isr_any),
        .isr_top_id (isr_top_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (inta) state_n = WAIT2;
            WAIT2: if (inta) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack = 1'b0;
        fin = 1'b0;
        unique case (state)
            IDLE:  ack = inta;
            WAIT2: fin = inta;
            default: ;
        endcase
    end

    // seoi outranks eoi; both only act on a bit that is actually in service
    always_comb begin
        seoi_hit = seoi && (32'(seoi_id) < 32'(NUM_IRQ)) && isr[seoi_id];
        eoi_hit  = eoi && !seoi && isr_any;
        aeoi_hit = fin && aeoi && !spur;
        clr_mask = '0;
        set_mask = '0;
        if (seoi_hit) clr_mask[seoi_id] = 1'b1;
        if (eoi_hit) clr_mask[isr_top_id] = 1'b1;
        if (aeoi_hit) clr_mask[id] = 1'b1;
        if (ack && cand_valid) set_mask[cand_id] = 1'b1;
    end

    always_comb begin
        isr_n = (isr & ~clr_mask) | set_mask;
        if (ltim) begin
            irr_n = ir & ~set_mask;
        end else begin
            irr_n = (irr & ~set_mask) | (ir & ~ir_q);
        end
    end

    always_comb begin
        lp_n = lp;
        if (!rotate) begin
            lp_n = LAST;
        end else if (seoi_hit) begin
            lp_n = seoi_id;
        end else if (eoi_hit) begin
            lp_n = isr_top_id;
        end else if (aeoi_hit) begin
            lp_n = id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            irr       <= '0;
            isr       <= '0;
            lp        <= LAST;
            id        <= '0;
            spur      <= 1'b0;
            intr      <= 1'b0;
            vec       <= '0;
            vec_valid <= 1'b0;
        end else begin
            ir_q      <= ir;
            irr       <= irr_n;
            isr       <= isr_n;
            lp        <= lp_n;
            intr      <= (state == IDLE) && !inta && cand_valid;
            vec_valid <= fin;
            if (ack) begin
                id   <= cand_valid ? cand_id : LAST;
                spur <= !cand_valid;
            end
            if (fin) begin
                vec <= {vec_base, id};
            end
        end
    end

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Directed bench for pic_ctrl_seq with a vector scoreboard.
// Two instances: NUM_IRQ=8 (main) and NUM_IRQ=16 (reset abort).
module tb_pic_ctrl_seq;

    logic       clk;
    logic       reset;
    logic [7:0] ir, imr;
    logic       ltim, aeoi, rotate;
    logic [4:0] vec_base;
    logic       inta, eoi, seoi;
    logic [2:0] seoi_id;
    logic       intr;
    logic [7:0] vec;
    logic       vec_valid;
    logic [7:0] irr, isr;

    logic [15:0] b_ir, b_imr;
    logic [3:0]  b_vec_base;
    logic        b_inta;
    logic [3:0]  b_seoi_id;
    logic        b_intr;
    logic [7:0]  b_vec;
    logic        b_vec_valid;
    logic [15:0] b_irr, b_isr;

    int checks = 0;
    int failures = 0;
    int b_vv_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_vec;

    pic_ctrl_seq #(.NUM_IRQ(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .imr       (imr),
        .ltim      (ltim),
        .aeoi      (aeoi),
        .rotate    (rotate),
        .vec_base  (vec_base),
        .inta      (inta),
        .eoi       (eoi),
        .seoi      (seoi),
        .seoi_id   (seoi_id),
        .intr      (intr),
        .vec       (vec),
        .vec_valid (vec_valid),
        .irr       (irr),
        .isr       (isr)
    );

    pic_ctrl_seq #(.NUM_IRQ(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .ir        (b_ir),
        .imr       (b_imr),
        .ltim      (1'b0),
        .aeoi      (1'b0),
        .rotate    (1'b0),
        .vec_base  (b_vec_base),
        .inta      (b_inta),
        .eoi       (1'b0),
        .seoi      (1'b0),
        .seoi_id   (b_seoi_id),
        .intr      (b_intr),
        .vec       (b_vec),
        .vec_valid (b_vec_valid),
        .irr       (b_irr),
        .isr       (b_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack1();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic ack2(input logic [7:0] e);
        tick();
        sb.push_back(e);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        chk("vv_hi", 32'(vec_valid), 1);
        tick();
        chk("vv_lo", 32'(vec_valid), 0);
    endtask

    task automatic pulse_ir(input logic [7:0] v);
        ir = v;
        tick();
        ir = 8'h00;
        tick();
    endtask

    always @(negedge clk) begin
        if (vec_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL vec_unexpected observed=%0h expected=none", vec);
            end
            if (sb.size() > 0) begin
                exp_vec = sb.pop_front();
                assert (vec === exp_vec) else begin
                    failures++;
                    $error("FAIL vec observed=%0h expected=%0h", vec, exp_vec);
                end
            end
        end
        if (b_vec_valid) b_vv_cnt++;
    end

    initial begin
        reset = 1'b1;
        ir = '0; imr = '0; ltim = 0; aeoi = 0; rotate = 0;
        vec_base = 5'h08; inta = 0; eoi = 0; seoi = 0; seoi_id = '0;
        b_ir = '0; b_imr = '0; b_vec_base = 4'h3; b_inta = 0; b_seoi_id = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_irr", 32'(irr), 0);
        chk("rst_isr", 32'(isr), 0);
        chk("rst_intr", 32'(intr), 0);
        chk("rst_vec", 32'(vec), 0);
        chk("rst_vv", 32'(vec_valid), 0);

        // basic edge, fixed priority
        ir = 8'h04;
        tick();
        chk("e_irr", 32'(irr), 32'h04);
        chk("e_intr_k", 32'(intr), 0);
        ir = 8'h00;
        tick();
        chk("e_intr_k1", 32'(intr), 1);
        ack1();
        chk("e_isr", 32'(isr), 32'h04);
        chk("e_irr_clr", 32'(irr), 0);
        chk("e_intr_fall", 32'(intr), 0);
        ack2(8'h42);
        chk("e_isr2", 32'(isr), 32'h04);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("e_eoi", 32'(isr), 0);

        // nesting
        pulse_ir(8'h20);
        chk("n_intr5", 32'(intr), 1);
        ack1();
        ack2(8'h45);
        pulse_ir(8'h04);
        chk("n_intr2", 32'(intr), 1);
        ack1();
        chk("n_isr24", 32'(isr), 32'h24);
        ack2(8'h42);
        pulse_ir(8'h80);
        tick();
        chk("n_blk_intr", 32'(intr), 0);
        chk("n_blk_irr", 32'(irr), 32'h80);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("n_eoi1", 32'(isr), 32'h20);
        tick();
        chk("n_blk2", 32'(intr), 0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("n_eoi2", 32'(isr), 0);
        tick();
        chk("n_intr7", 32'(intr), 1);
        ack1();
        ack2(8'h47);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("n_done", 32'(isr), 0);

        // mask and level
        ltim = 1'b1;
        imr = 8'h01;
        ir = 8'h01;
        tick();
        chk("l_irr", 32'(irr), 32'h01);
        tick();
        chk("l_masked", 32'(intr), 0);
        imr = 8'h00;
        tick();
        chk("l_unmask", 32'(intr), 1);
        ir = 8'h00;
        tick();
        chk("l_irr_drop", 32'(irr), 0);
        tick();
        chk("l_intr_fall", 32'(intr), 0);
        ltim = 1'b0;
        tick();

        // AEOI with rotation
        aeoi = 1'b1;
        rotate = 1'b1;
        pulse_ir(8'h09);
        chk("a_intr", 32'(intr), 1);
        ack1();
        chk("a_isr_set", 32'(isr), 32'h01);
        chk("a_irr", 32'(irr), 32'h08);
        ack2(8'h40);
        chk("a_isr_auto", 32'(isr), 0);
        chk("a_intr3", 32'(intr), 1);
        ack1();
        ack2(8'h43);
        pulse_ir(8'h11);
        ack1();
        ack2(8'h44);
        ack1();
        ack2(8'h40);
        chk("a_isr_end", 32'(isr), 0);
        aeoi = 1'b0;
        rotate = 1'b0;
        tick();

        // spurious acknowledge
        ack1();
        chk("s_isr", 32'(isr), 0);
        ack2(8'h47);
        chk("s_isr2", 32'(isr), 0);

        // specific EOI with rotation
        pulse_ir(8'h20);
        ack1();
        ack2(8'h45);
        pulse_ir(8'h10);
        chk("se_intr4", 32'(intr), 1);
        ack1();
        ack2(8'h44);
        chk("se_isr30", 32'(isr), 32'h30);
        rotate = 1'b1;
        seoi = 1'b1;
        seoi_id = 3'd5;
        tick();
        seoi = 1'b0;
        chk("se_isr10", 32'(isr), 32'h10);
        pulse_ir(8'h41);
        chk("se_intr6", 32'(intr), 1);
        ack1();
        chk("se_isr50", 32'(isr), 32'h50);
        ack2(8'h46);
        seoi = 1'b1;
        seoi_id = 3'd6;
        tick();
        seoi_id = 3'd4;
        tick();
        seoi = 1'b0;
        chk("se_clr", 32'(isr), 0);
        tick();
        ack1();
        ack2(8'h40);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        rotate = 1'b0;
        chk("se_done", 32'(isr), 0);

        // reset in the middle of an acknowledge, both sizes
        ir = 8'h02;
        b_ir = 16'h0100;
        tick();
        ir = 8'h00;
        b_ir = 16'h0000;
        tick();
        chk("r_intr", 32'(intr), 1);
        chk("r16_intr", 32'(b_intr), 1);
        inta = 1'b1;
        b_inta = 1'b1;
        tick();
        inta = 1'b0;
        b_inta = 1'b0;
        chk("r_isr", 32'(isr), 32'h02);
        chk("r16_isr", 32'(b_isr), 32'h0100);
        reset = 1'b1;
        #1;
        chk("r_isr0", 32'(isr), 0);
        chk("r_intr0", 32'(intr), 0);
        chk("r16_isr0", 32'(b_isr), 0);
        chk("r16_intr0", 32'(b_intr), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("r_vv", 32'(vec_valid), 0);
        chk("r_vec", 32'(vec), 0);
        chk("r16_vv_cnt", 32'(b_vv_cnt), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
